mux_share_arbiter: RTL and testbench

- Round-robin arbiter that time-shares the 4-bit 2-to-1 datapath mux (inputs X, Y, select s, output M) between two streaming requesters.
- Owns the mux select and a registered output stage.
- Applies valid/ready handshakes on both inputs and on the output.
- Bounds each grant to MAX_HOLD beats when the other side is waiting.

---
 rtl/mux_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux_share_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter sharing a 2-to-1 datapath mux between two valid/ready streams,
// with a registered output stage. Define MUX_ARB_STATS_EN to add per-requester beat counters.
module mux_share_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_data,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [WIDTH-1:0] y_data,
  input  logic             y_valid,
  output logic             y_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             sel
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0]      x_beats,
  output logic [15:0]      y_beats
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_X = 2'd1;
  localparam logic [1:0] ST_GNT_Y = 2'd2;
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [1:0] state, state_nxt;
  logic       last, last_nxt;
  logic       sel_nxt;
  logic [3:0] hold_cnt, hold_nxt, hold_inc;
  logic       can_load, xfer_x, xfer_y, load_p0;

  assign can_load = ~m_valid | m_ready;
  assign x_ready  = (state == ST_GNT_X) & can_load;
  assign y_ready  = (state == ST_GNT_Y) & can_load;
  assign xfer_x   = x_valid & x_ready;
  assign xfer_y   = y_valid & y_ready;
  assign load_p0  = xfer_x | xfer_y;
  assign hold_inc = hold_cnt + 4'd1;

  // last: 0 = X served most recently, 1 = Y; the idle tie goes to the other side
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = sel;
    hold_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (x_valid && (!y_valid || last)) begin
          state_nxt = ST_GNT_X;
          sel_nxt   = 1'b0;
          hold_nxt  = 4'd0;
        end else if (y_valid) begin
          state_nxt = ST_GNT_Y;
          sel_nxt   = 1'b1;
          hold_nxt  = 4'd0;
        end
      end
      ST_GNT_X: begin
        if (!x_valid) begin
          state_nxt = ST_IDLE;
          hold_nxt  = 4'd0;
          last_nxt  = 1'b0;
        end else if (xfer_x) begin
          if (hold_inc == HOLD_MAX) begin
            hold_nxt = 4'd0;
            if (y_valid) begin
              state_nxt = ST_GNT_Y;
              sel_nxt   = 1'b1;
              last_nxt  = 1'b0;
            end
          end else begin
            hold_nxt = hold_inc;
          end
        end
      end
      ST_GNT_Y: begin
        if (!y_valid) begin
          state_nxt = ST_IDLE;
          hold_nxt  = 4'd0;
          last_nxt  = 1'b1;
        end else if (xfer_y) begin
          if (hold_inc == HOLD_MAX) begin
            hold_nxt = 4'd0;
            if (x_valid) begin
              state_nxt = ST_GNT_X;
              sel_nxt   = 1'b0;
              last_nxt  = 1'b1;
            end
          end else begin
            hold_nxt = hold_inc;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hold_nxt  = 4'd0;
      end
    endcase
  end

  // Output stage: a drain and a load in the same cycle keep m_valid high with no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      sel      <= 1'b0;
      hold_cnt <= 4'd0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      sel      <= sel_nxt;
      hold_cnt <= hold_nxt;
      m_valid  <= load_p0 | (m_valid & ~m_ready);
      if (xfer_x)
        m_data <= x_data;
      else if (xfer_y)
        m_data <= y_data;
    end
  end

`ifdef MUX_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      x_beats <= 16'd0;
      y_beats <= 16'd0;
    end else begin
      if (xfer_x && (x_beats != 16'hFFFF))
        x_beats <= x_beats + 16'd1;
      if (xfer_y && (y_beats != 16'hFFFF))
        y_beats <= y_beats + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Bench for mux_share_arbiter: directed steps plus random traffic against a
// behavioural grant/ownership model and an in-order beat scoreboard.
module tb_mux_share_arbiter;
  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] x_data, y_data, m_data;
  logic             x_valid, x_ready, y_valid, y_ready, m_valid, m_ready, sel;
`ifdef MUX_ARB_STATS_EN
  logic [15:0]      x_beats, y_beats;
`endif

  always #5 clk = ~clk;

  mux_share_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .sel(sel)
`ifdef MUX_ARB_STATS_EN
    , .x_beats(x_beats), .y_beats(y_beats)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: owner 0 = nobody, 1 = X, 2 = Y; run = beats taken in current grant
  int         owner;
  int         run;
  bit         last_y;
  bit         m_sel;
  bit         mv;
  logic [3:0] md;
  int         xb, yb;
  logic [3:0] sb[$];
  bit         armed = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; run = 0; last_y = 1'b1; m_sel = 1'b0;
    mv = 1'b0; md = 4'd0; xb = 0; yb = 0;
    sb.delete();
  endtask

  task automatic step(input bit r, input bit xv, input logic [3:0] xd,
                      input bit yv, input logic [3:0] yd, input bit mr);
    bit can, exr, eyr;
    rst = r; x_valid = xv; x_data = xd; y_valid = yv; y_data = yd; m_ready = mr;
    @(negedge clk);
    can = !mv || mr;
    exr = (owner == 1) && can;
    eyr = (owner == 2) && can;
    if (armed) begin
      chk("x_ready", 16'(x_ready), 16'(exr));
      chk("y_ready", 16'(y_ready), 16'(eyr));
      chk("m_valid", 16'(m_valid), 16'(mv));
      chk("m_data",  16'(m_data),  16'(md));
      chk("sel",     16'(sel),     16'(m_sel));
`ifdef MUX_ARB_STATS_EN
      chk("x_beats", x_beats, 16'(xb));
      chk("y_beats", y_beats, 16'(yb));
`endif
      if (m_valid && m_ready) begin
        chk("sb_nonempty", 16'(sb.size() > 0), 16'd1);
        if (sb.size() > 0)
          chk("sb_order", 16'(m_data), 16'(sb.pop_front()));
      end
    end
    if (r) begin
      model_reset();
      armed = 1'b1;
    end else begin
      if (exr && xv) begin
        sb.push_back(xd);
        if (xb < 65535) xb++;
        mv = 1'b1; md = xd;
      end else if (eyr && yv) begin
        sb.push_back(yd);
        if (yb < 65535) yb++;
        mv = 1'b1; md = yd;
      end else if (mv && mr) begin
        mv = 1'b0;
      end
      case (owner)
        0: begin
          if (xv && yv) owner = last_y ? 1 : 2;
          else if (xv)  owner = 1;
          else if (yv)  owner = 2;
          if (owner != 0) begin
            m_sel = (owner == 2);
            run = 0;
          end
        end
        1: begin
          if (!xv) begin
            owner = 0; run = 0; last_y = 1'b0;
          end else if (exr) begin
            run++;
            if (run == MAX_HOLD) begin
              run = 0;
              if (yv) begin owner = 2; m_sel = 1'b1; last_y = 1'b0; end
            end
          end
        end
        default: begin
          if (!yv) begin
            owner = 0; run = 0; last_y = 1'b1;
          end else if (eyr) begin
            run++;
            if (run == MAX_HOLD) begin
              run = 0;
              if (xv) begin owner = 1; m_sel = 1'b0; last_y = 1'b1; end
            end
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rd();
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    model_reset();
    rst = 1'b1; x_valid = 1'b0; y_valid = 1'b0; x_data = '0; y_data = '0; m_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1, bit'($urandom_range(0, 1)), rd(), bit'($urandom_range(0, 1)), rd(), bit'($urandom_range(0, 1)));
    chk("rst_m_valid", 16'(m_valid), 16'd0);
    chk("rst_m_data",  16'(m_data),  16'd0);
    chk("rst_sel",     16'(sel),     16'd0);
    chk("rst_x_ready", 16'(x_ready), 16'd0);
    chk("rst_y_ready", 16'(y_ready), 16'd0);

    // X only: ready one cycle after request, data the cycle after that
    step(0, 1, 4'b1010, 0, rd(), 1);
    chk("xonly_ready", 16'(x_ready), 16'd1);
    step(0, 1, 4'b1010, 0, rd(), 1);
    chk("xonly_m_valid", 16'(m_valid), 16'd1);
    chk("xonly_m_data",  16'(m_data),  16'hA);
    chk("xonly_sel",     16'(sel),     16'd0);
    step(0, 1, rd(), 0, rd(), 1);
    step(0, 1, rd(), 0, rd(), 1);

    // Contention from a fresh reset: X first, alternating every MAX_HOLD beats
    step(1, 0, rd(), 0, rd(), 1);
    step(0, 1, rd(), 1, rd(), 1);
    chk("cont_first_x", 16'(sel), 16'd0);
    for (int i = 0; i < 4; i++) step(0, 1, rd(), 1, rd(), 1);
    chk("cont_switch_y", 16'(sel), 16'd1);
    for (int i = 0; i < 4; i++) step(0, 1, rd(), 1, rd(), 1);
    chk("cont_switch_x", 16'(sel), 16'd0);
    for (int i = 0; i < 6; i++) step(0, 1, rd(), 1, rd(), 1);

    // Backpressure mid-stream
    step(0, 1, rd(), 1, rd(), 0);
    chk("bp_x_ready", 16'(x_ready), 16'd0);
    chk("bp_y_ready", 16'(y_ready), 16'd0);
    step(0, 1, rd(), 1, rd(), 0);
    step(0, 1, rd(), 1, rd(), 0);
    for (int i = 0; i < 8; i++) step(0, 1, rd(), 1, rd(), 1);

    // Release and rotation
    step(0, 0, rd(), 0, rd(), 1);
    step(0, 0, rd(), 0, rd(), 1);
    step(0, 0, rd(), 1, 4'b1100, 1);
    step(0, 0, rd(), 1, 4'b1100, 1);
    step(0, 0, rd(), 1, 4'b1100, 1);
    chk("rot_y_data", 16'(m_data), 16'hC);
    step(0, 0, rd(), 0, rd(), 1);
    chk("rot_sel_hold", 16'(sel), 16'd1);
    step(0, 1, rd(), 1, rd(), 1);
    chk("rot_x_wins", 16'(sel), 16'd0);

    // Reset mid-burst while Y owns the output
    step(0, 0, rd(), 1, rd(), 1);
    step(0, 0, rd(), 1, rd(), 1);
    step(0, 0, rd(), 1, rd(), 1);
    chk("mid_pre_valid", 16'(m_valid), 16'd1);
    chk("mid_pre_sel",   16'(sel),     16'd1);
    step(1, 0, rd(), 1, rd(), 0);
    chk("mid_m_valid", 16'(m_valid), 16'd0);
    chk("mid_sel",     16'(sel),     16'd0);
`ifdef MUX_ARB_STATS_EN
    chk("mid_x_beats", x_beats, 16'd0);
    chk("mid_y_beats", y_beats, 16'd0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, rd(),
           $urandom_range(0, 3) != 0, rd(), $urandom_range(0, 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
